if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 16-bit pipelined CPU. It sits directly upstream of the ID stage. It owns the PC and issues req/ack reads to instruction memory. Fetched words are buffered in a small skid FIFO and presented to ID as a registered {instruction, pc, valid} triple. It handles ID stalls, branch redirects from EX, and the HALT opcode.

Parameters:
PC_WIDTH, 8, instruction address width; PC increments by 1 per instruction word.
INSTR_WIDTH, 16, instruction word width.
RESET_PC, 0, PC value after reset.
BUF_DEPTH, 2, fetch buffer entries (power of two, >=2).

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
enable  input  1  run control; fetch proceeds only while 1.
imem_req  output  1  read request to instruction memory.
imem_addr  output  PC_WIDTH  read address; stable while imem_req=1 and no ack.
imem_ack  input  1  read complete; imem_rdata valid this cycle.
imem_rdata  input  INSTR_WIDTH  instruction word.
stall  input  1  ID cannot accept; hold outputs.
branch_taken  input  1  redirect from EX.
branch_target  input  PC_WIDTH  redirect address.
if_instruction  output  INSTR_WIDTH  instruction to ID; NOP (16'h0000) when invalid.
if_pc  output  PC_WIDTH  address of if_instruction.
if_valid  output  1  if_instruction is a real fetched word.
halted  output  1  fetch stopped on HALT.

Behaviour:
- Reset (async, reset=0) forces:
  - pc=RESET_PC; state IDLE; buffer empty; drop flag=0.
  - if_instruction=16'h0000, if_pc=0, if_valid=0, imem_req=0, halted=0.
- FSM states: IDLE, FETCH, DRAIN, HALT.
  - IDLE: imem_req=0. Go to FETCH when enable=1.
  - FETCH: imem_req=1 iff (buffer count + outstanding) < BUF_DEPTH.
    - On request issue, latch req_addr<=pc, which drives imem_addr until ack.
    - At most one request outstanding. Ack may arrive in the issue cycle (zero-wait) or later.
  - Ack accepted (drop=0): push {req_addr, imem_rdata}; pc<=req_addr+1, wrapping mod 2^PC_WIDTH.
    - If imem_rdata[15:11]==`HALT, go to HALT. The HALT word itself is pushed.
  - enable=0 in FETCH: go to DRAIN if a request is outstanding, else IDLE.
  - DRAIN: no new request; go to IDLE on ack (word still pushed). pc is retained.
  - HALT: imem_req=0, halted=1. Leave only on branch_taken (to FETCH) or reset.
- Output register, updated each edge:
  - branch_taken=1 (highest priority, overrides stall):
    - flush buffer; pc<=branch_target.
    - if_instruction<=NOP, if_valid<=0; halted<=0; state FETCH.
    - Ack in the same cycle is discarded.
    - Request outstanding without ack: set drop=1. imem_addr holds the old address until the ack; that ack is discarded, drop clears, and the next request uses branch_target.
  - else stall=1: outputs hold. Buffer may still fill.
  - else buffer non-empty: pop head into if_instruction/if_pc, if_valid<=1.
  - else: if_instruction<=NOP, if_valid<=0.
- Latency and throughput:
  - Ack at edge E: word appears on outputs after edge E+1 (no bypass).
  - Zero-wait memory sustains one instruction per cycle with BUF_DEPTH=2.
- Boundaries:
  - Push and pop in the same cycle are allowed at any count.
  - Full buffer deasserts imem_req.
  - Stall held indefinitely: no loss or duplication of words.
  - PC 8'hFF+1 wraps to 8'h00.
  - Reset mid-request: discard state. Memory must tolerate request withdrawal.

Decomposition:
- Shared defines file (the same one ID uses): opcode constants `NOP, `HALT, `LOAD, `STORE, `BZ, `BN, etc., and the NOP encoding 16'h0000.
- Sub-module if_fetch_buffer: synchronous FIFO, BUF_DEPTH x (PC_WIDTH+INSTR_WIDTH), with push, pop, flush, count, full, empty.

Test Plan:
- Reset release, enable=1, zero-wait memory returning word=addr+16'h0800 -> if_pc 0,1,2,3 on consecutive cycles after first ack; if_valid=1 continuously; first valid 2 cycles after first imem_req.
- stall=1 for 5 cycles mid-stream at if_pc=3 -> if_instruction/if_pc frozen at 3; at most 2 extra reads issued; after release, if_pc 4,5,6 with no gaps or repeats.
- branch_taken with target 8'h40 while a 3-wait-state read of addr 5 is outstanding -> if_valid=0 next cycle; imem_addr stays 5 until ack; that data is never output; next imem_addr=8'h40; next valid if_pc=8'h40.
- Memory returns HALT opcode at addr 7 -> if_pc=7 output with if_valid=1; imem_req=0 thereafter; halted=1; subsequent branch_taken to 8'h10 clears halted and resumes at 8'h10.
- Branch_taken and imem_ack in the same cycle, with stall=1 -> acked data dropped; outputs become NOP/valid=0 despite stall; pc=target.
- Start at pc=8'hFE, free-run -> if_pc FE, FF, 00, 01; async reset asserted mid-read -> all outputs to reset values immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the opcode field layout and constants common to IF and ID, the NOP encoding,
// the fetch FSM state type and a HALT-detect helper.
package if_fetch_pkg;

    localparam int unsigned OPCODE_W = 5;

    // Opcode lives in instr[15:11]; only HALT is decoded by fetch.
    localparam logic [OPCODE_W-1:0] OP_NOP   = 5'h00;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 5'h01;
    localparam logic [OPCODE_W-1:0] OP_STORE = 5'h02;
    localparam logic [OPCODE_W-1:0] OP_BZ    = 5'h0c;
    localparam logic [OPCODE_W-1:0] OP_BN    = 5'h0d;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 5'h1f;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StHalt
    } fetch_state_e;

    function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode);
        return opcode == OP_HALT;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Bundle of every non-clock/reset signal of the fetch stage.
//   enable                         run control
//   imem_req/imem_addr             read request to instruction memory (held until ack)
//   imem_ack/imem_rdata            read completion and data
//   stall                          ID cannot accept
//   branch_taken/branch_target     redirect from EX
//   if_instruction/if_pc/if_valid  registered triple presented to ID
//   halted                         fetch stopped on HALT
// master = fetch stage side, slave = memory/pipeline side.
interface if_fetch_if #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 16
);
    logic                   enable;
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   stall;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic [INSTR_WIDTH-1:0] if_instruction;
    logic [PC_WIDTH-1:0]    if_pc;
    logic                   if_valid;
    logic                   halted;

    modport master (
        input  enable, imem_ack, imem_rdata, stall, branch_taken, branch_target,
        output imem_req, imem_addr, if_instruction, if_pc, if_valid, halted
    );

    modport slave (
        output enable, imem_ack, imem_rdata, stall, branch_taken, branch_target,
        input  imem_req, imem_addr, if_instruction, if_pc, if_valid, halted
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// Synchronous skid FIFO between instruction memory and the IF output register.
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   push_i/wdata_i        write an entry
//   pop_i/rdata_o         consume the head (rdata_o shows the head combinationally)
//   flush_i               empty the FIFO; wins over push/pop
//   count_o/full_o/empty_o occupancy
// Depth must be a power of two so the pointers wrap naturally.
module if_fetch_buffer #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                count_d = count_q + 1'b1;
            end else if (!push_i && pop_i) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 16-bit pipelined CPU.
// Owns the PC, issues req/ack reads to instruction memory, buffers returned words in a
// small FIFO and presents a registered {instruction, pc, valid} triple to ID. Handles ID
// stalls, EX branch redirects (with discard of an in-flight read) and the HALT opcode.
//   clock   rising-edge clock
//   reset   asynchronous active-low reset
//   bus     if_fetch_if master modport (parameters must match this module's)
module if_fetch_stage
    import if_fetch_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = 8,
    parameter int unsigned         INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned         BUF_DEPTH   = 2
) (
    input logic        clock,
    input logic        reset,
    if_fetch_if.master bus
);
    localparam int unsigned         EntryW      = PC_WIDTH + INSTR_WIDTH;
    localparam int unsigned         CntW        = $clog2(BUF_DEPTH) + 1;
    localparam logic [CntW-1:0]     BufDepthCnt = CntW'(BUF_DEPTH);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    req_addr_q, req_addr_d;
    logic                   outstanding_q, outstanding_d;
    logic                   drop_q, drop_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    out_pc_q, out_pc_d;
    logic                   valid_q, valid_d;

    logic                   new_issue;
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   ack;
    logic                   ack_take;

    logic                   buf_push;
    logic                   buf_pop;
    logic                   buf_flush;
    logic [EntryW-1:0]      buf_rdata;
    logic [CntW-1:0]        buf_count;
    logic                   buf_full;
    logic                   buf_empty;

    // A new read starts only with no read in flight and a free slot for its word; once
    // issued, req stays high with a stable address until the ack, so a reserved slot is
    // never lost and full always implies no request.
    assign new_issue = (state_q == StFetch) && bus.enable && !outstanding_q &&
                       (buf_count < BufDepthCnt);
    assign imem_req  = outstanding_q || new_issue;
    assign imem_addr = outstanding_q ? req_addr_q : pc_q;
    assign ack       = imem_req && bus.imem_ack;
    assign ack_take  = ack && !drop_q && !bus.branch_taken;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        instr_d       = instr_q;
        out_pc_d      = out_pc_q;
        valid_d       = valid_q;
        buf_pop       = 1'b0;

        // Request tracking: a cycle with req and no ack leaves a read in flight.
        if (imem_req && !bus.imem_ack) begin
            outstanding_d = 1'b1;
            req_addr_d    = imem_addr;
        end else if (ack) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (!bus.enable) begin
                    state_d = (imem_req && !bus.imem_ack) ? StDrain : StIdle;
                end
            end
            StDrain: begin
                if (ack) begin
                    state_d = StIdle;
                end
            end
            StHalt: begin
            end
            default: state_d = StIdle;
        endcase

        if (ack_take) begin
            pc_d = imem_addr + 1'b1;
            if (is_halt(bus.imem_rdata[INSTR_WIDTH-1 -: OPCODE_W])) begin
                state_d = StHalt;
            end
        end

        if (bus.branch_taken) begin
            state_d = StFetch;
            pc_d    = bus.branch_target;
            // A read left in flight must complete on the bus but its data is discarded.
            drop_d  = imem_req && !bus.imem_ack;
            instr_d = INSTR_WIDTH'(NOP_INSTR);
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            if (!buf_empty) begin
                buf_pop             = 1'b1;
                {out_pc_d, instr_d} = buf_rdata;
                valid_d             = 1'b1;
            end else begin
                instr_d = INSTR_WIDTH'(NOP_INSTR);
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            req_addr_q    <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            instr_q       <= INSTR_WIDTH'(NOP_INSTR);
            out_pc_q      <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            instr_q       <= instr_d;
            out_pc_q      <= out_pc_d;
            valid_q       <= valid_d;
        end
    end

    assign buf_push  = ack_take;
    assign buf_flush = bus.branch_taken;

    if_fetch_buffer #(
        .Depth (BUF_DEPTH),
        .Width (EntryW)
    ) u_buffer (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .flush_i (buf_flush),
        .wdata_i ({imem_addr, bus.imem_rdata}),
        .rdata_o (buf_rdata),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    // The slot reservation above must make an overflowing push impossible.
    assert property (@(posedge clock) disable iff (!reset) buf_push |-> (!buf_full || buf_pop));

    assign bus.imem_req       = imem_req;
    assign bus.imem_addr      = imem_addr;
    assign bus.if_instruction = instr_q;
    assign bus.if_pc          = out_pc_q;
    assign bus.if_valid       = valid_q;
    assign bus.halted         = (state_q == StHalt);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a per-cycle vector table for the stream, stall,
// HALT and branch-with-ack cases, then hand-written sequences for a redirect over a
// wait-stated read, PC wrap and asynchronous reset during a read.
module tb_if_fetch_stage;

    logic clock;
    logic reset;

    if_fetch_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();

    if_fetch_stage #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (16),
        .RESET_PC    (8'h00),
        .BUF_DEPTH   (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: word = addr + 16'h0800, HALT word at halt_addr, wait_states per read.
    int   wait_states;
    int   halt_addr;
    int   wait_cnt;
    logic mem_ack;

    always_comb begin
        mem_ack = bus.imem_req && (wait_cnt >= wait_states);
    end
    assign bus.imem_ack   = mem_ack;
    assign bus.imem_rdata = (int'(bus.imem_addr) == halt_addr) ? 16'hF800 :
                            16'h0800 + {8'h00, bus.imem_addr};

    always @(posedge clock or negedge reset) begin
        if (!reset)                        wait_cnt <= 0;
        else if (!bus.imem_req || mem_ack) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
    end

    int n_vec;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en, st, br;
        logic [7:0]  tgt;
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_valid;
        logic [7:0]  e_pc;
        logic [15:0] e_instr;
        logic        e_halt;
    } vec_t;

    function automatic vec_t mk(input int en, input int st, input int br, input int tgt,
                                input int rq, input int addr, input int vl, input int pc,
                                input int instr, input int hl);
        vec_t v;
        v.en = (en != 0); v.st = (st != 0); v.br = (br != 0); v.tgt = 8'(tgt);
        v.e_req = (rq != 0); v.e_addr = 8'(addr); v.e_valid = (vl != 0);
        v.e_pc = 8'(pc); v.e_instr = 16'(instr); v.e_halt = (hl != 0);
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_outputs(input string tag, input logic rq, input logic [7:0] addr,
                               input logic vl, input logic [7:0] pc, input logic [15:0] instr,
                               input logic hl);
        chk({tag, ".req"}, 32'(bus.imem_req), 32'(rq));
        if (rq) chk({tag, ".addr"}, 32'(bus.imem_addr), 32'(addr));
        chk({tag, ".valid"}, 32'(bus.if_valid), 32'(vl));
        if (vl) chk({tag, ".pc"}, 32'(bus.if_pc), 32'(pc));
        chk({tag, ".instr"}, 32'(bus.if_instruction), vl ? 32'(instr) : 32'h0);
        chk({tag, ".halted"}, 32'(bus.halted), 32'(hl));
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       found;
        logic [7:0] got[$];
        int         gaps;

        n_vec = 0;
        n_bad = 0;
        wait_states = 0;
        halt_addr = 7;
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 8'h00;

        //                en st br tgt   req addr  vl pc     instr    halt
        tbl.push_back(mk(1, 0, 0, 0,     0, 0,     0, 0,     0,       0)); // IDLE->FETCH
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h00, 0, 0,     0,       0));
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h01, 0, 0,     0,       0));
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h02, 1, 8'h00, 16'h0800, 0)); // first valid
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h03, 1, 8'h01, 16'h0801, 0));
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h04, 1, 8'h02, 16'h0802, 0));
        tbl.push_back(mk(1, 1, 0, 0,     1, 8'h05, 1, 8'h03, 16'h0803, 0)); // stall x5
        tbl.push_back(mk(1, 1, 0, 0,     0, 0,     1, 8'h03, 16'h0803, 0)); // buffer full
        tbl.push_back(mk(1, 1, 0, 0,     0, 0,     1, 8'h03, 16'h0803, 0));
        tbl.push_back(mk(1, 1, 0, 0,     0, 0,     1, 8'h03, 16'h0803, 0));
        tbl.push_back(mk(1, 1, 0, 0,     0, 0,     1, 8'h03, 16'h0803, 0));
        tbl.push_back(mk(1, 0, 0, 0,     0, 0,     1, 8'h03, 16'h0803, 0));
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h06, 1, 8'h04, 16'h0804, 0));
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h07, 1, 8'h05, 16'h0805, 0)); // HALT read
        tbl.push_back(mk(1, 0, 0, 0,     0, 0,     1, 8'h06, 16'h0806, 1));
        tbl.push_back(mk(1, 0, 0, 0,     0, 0,     1, 8'h07, 16'hF800, 1));
        tbl.push_back(mk(1, 0, 0, 0,     0, 0,     0, 0,     0,       1));
        tbl.push_back(mk(1, 0, 1, 8'h10, 0, 0,     0, 0,     0,       1)); // leave HALT
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h10, 0, 0,     0,       0));
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h11, 0, 0,     0,       0));
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h12, 1, 8'h10, 16'h0810, 0));
        tbl.push_back(mk(1, 1, 1, 8'h30, 1, 8'h13, 1, 8'h11, 16'h0811, 0)); // br+ack+stall
        tbl.push_back(mk(1, 1, 0, 0,     1, 8'h30, 0, 0,     0,       0));
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h31, 0, 0,     0,       0));
        tbl.push_back(mk(1, 0, 0, 0,     1, 8'h32, 1, 8'h30, 16'h0830, 0));

        // Reset state.
        next_cycle();
        next_cycle();
        chk_outputs("reset", 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0);
        chk("reset.pc", 32'(bus.if_pc), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.enable        = tbl[i].en;
            bus.stall         = tbl[i].st;
            bus.branch_taken  = tbl[i].br;
            bus.branch_target = tbl[i].tgt;
            @(negedge clock);
            chk_outputs($sformatf("v%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                        tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_halt);
            next_cycle();
        end
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;

        // Redirect to 8'h40 while a 3-wait read of address 5 is in flight.
        reset = 1'b0;
        halt_addr = -1;
        wait_states = 3;
        next_cycle();
        reset = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clock);
            if (bus.imem_req && bus.imem_addr == 8'h05 && !mem_ack) found = 1'b1;
            else next_cycle();
        end
        chk("br_wait.found_addr5", 32'(found), 32'h1);
        if (found) begin
            next_cycle();
            bus.branch_taken = 1'b1;
            bus.branch_target = 8'h40;
            next_cycle();
            bus.branch_taken = 1'b0;
            @(negedge clock);
            chk_outputs("br_wait.b1", 1'b1, 8'h05, 1'b0, 8'h00, 16'h0000, 1'b0);
            next_cycle();
            @(negedge clock);
            chk_outputs("br_wait.b2", 1'b1, 8'h05, 1'b0, 8'h00, 16'h0000, 1'b0);
            next_cycle();
            @(negedge clock);
            chk_outputs("br_wait.b3", 1'b1, 8'h40, 1'b0, 8'h00, 16'h0000, 1'b0);
            found = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                next_cycle();
                @(negedge clock);
                found = bus.if_valid;
            end
            chk("br_wait.valid_seen", 32'(found), 32'h1);
            chk("br_wait.first_pc", 32'(bus.if_pc), 32'h40);
            chk("br_wait.first_instr", 32'(bus.if_instruction), 32'h0840);
        end

        // Redirect to 8'hFE with zero-wait memory: PC wraps FF -> 00.
        next_cycle();
        wait_states = 0;
        bus.branch_taken = 1'b1;
        bus.branch_target = 8'hFE;
        next_cycle();
        bus.branch_taken = 1'b0;
        gaps = 0;
        for (int k = 0; k < 20 && got.size() < 4; k++) begin
            @(negedge clock);
            if (bus.if_valid) got.push_back(bus.if_pc);
            else if (got.size() > 0) gaps++;
            next_cycle();
        end
        chk("wrap.count", 32'(got.size()), 32'd4);
        chk("wrap.gaps", 32'(gaps), 32'd0);
        if (got.size() == 4) begin
            chk("wrap.pc0", 32'(got[0]), 32'hFE);
            chk("wrap.pc1", 32'(got[1]), 32'hFF);
            chk("wrap.pc2", 32'(got[2]), 32'h00);
            chk("wrap.pc3", 32'(got[3]), 32'h01);
        end

        // Asynchronous reset while a read is in flight.
        wait_states = 3;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            next_cycle();
            @(negedge clock);
            found = bus.imem_req && !mem_ack;
        end
        chk("rst_mid.found_read", 32'(found), 32'h1);
        chk("rst_mid.valid_before", 32'(bus.if_valid), 32'h1);
        reset = 1'b0;
        #1;
        chk_outputs("rst_mid", 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0);
        chk("rst_mid.pc", 32'(bus.if_pc), 32'h0);
        next_cycle();
        reset = 1'b1;
        wait_states = 0;
        @(negedge clock);
        chk("restart.idle_req", 32'(bus.imem_req), 32'h0);
        next_cycle();
        @(negedge clock);
        chk("restart.req", 32'(bus.imem_req), 32'h1);
        chk("restart.addr", 32'(bus.imem_addr), 32'h00);
        next_cycle();
        next_cycle();
        @(negedge clock);
        chk_outputs("restart.out", 1'b1, 8'h02, 1'b1, 8'h00, 16'h0800, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
